// File: rtl/a25_wishbone_resp_buf_if.sv
// Request/response bundle between an initiator, the response buffer and its memory target.
// Handshakes: a request moves when i_valid && o_accepted on a rising clock edge; a target
// request completes when o_mem_req && i_mem_ack on a rising edge; o_rdata_valid is a one-cycle strobe.
interface a25_wishbone_resp_buf_if;
   logic         i_valid;
   logic         o_accepted;
   logic         i_write;
   logic [127:0] i_wdata;
   logic [15:0]  i_be;
   logic [31:0]  i_addr;
   logic [127:0] o_rdata;
   logic         o_rdata_valid;
   logic         o_mem_req;
   logic         o_mem_we;
   logic [31:0]  o_mem_addr;
   logic [127:0] o_mem_wdata;
   logic [15:0]  o_mem_be;
   logic         i_mem_ack;
   logic [127:0] i_mem_rdata;

   modport slave (
      input  i_valid, i_write, i_wdata, i_be, i_addr, i_mem_ack, i_mem_rdata,
      output o_accepted, o_rdata, o_rdata_valid, o_mem_req, o_mem_we,
             o_mem_addr, o_mem_wdata, o_mem_be
   );

   modport master (
      output i_valid, i_write, i_wdata, i_be, i_addr, i_mem_ack, i_mem_rdata,
      input  o_accepted, o_rdata, o_rdata_valid, o_mem_req, o_mem_we,
             o_mem_addr, o_mem_wdata, o_mem_be
   );
endinterface

// File: rtl/a25_wishbone_resp_buf.sv
// Two-entry in-order request buffer with at most one outstanding read.
// Define A25_WBRESP_RDATA_REG_EN to register the read response (1 cycle after ack instead of 0).
module a25_wishbone_resp_buf (
   input logic                   i_clk,
   input logic                   i_rst,
   a25_wishbone_resp_buf_if.slave bus
);

   typedef struct packed {
      logic         write;
      logic [31:0]  addr;
      logic [127:0] wdata;
      logic [15:0]  be;
   } req_t;

   req_t       entry_q [2];
   req_t       entry_d [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;
   logic       read_pending_q, read_pending_d;

   logic       push;
   logic       pop;
   logic       rsp_fire;
   logic       rsp_valid;
   req_t       head;

   assign head       = entry_q[rd_ptr_q];
   assign push       = bus.o_accepted;
   assign pop        = bus.i_mem_ack && (count_q != 2'd0);
   assign rsp_fire   = pop && !head.write;

   assign bus.o_accepted  = bus.i_valid && (count_q != 2'd2) && !read_pending_q;
   assign bus.o_mem_req   = (count_q != 2'd0);
   assign bus.o_mem_we    = head.write;
   assign bus.o_mem_addr  = head.addr;
   assign bus.o_mem_wdata = head.wdata;
   assign bus.o_mem_be    = head.be;

`ifdef A25_WBRESP_RDATA_REG_EN
   logic [127:0] rdata_q, rdata_d;
   logic         rdata_valid_q, rdata_valid_d;

   always_comb begin
      rdata_d       = rsp_fire ? bus.i_mem_rdata : rdata_q;
      rdata_valid_d = rsp_fire;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
      end
   end

   assign rsp_valid = rdata_valid_q;
   assign bus.o_rdata = rdata_q;
`else
   assign rsp_valid = rsp_fire;
   assign bus.o_rdata = bus.i_mem_rdata;
`endif

   assign bus.o_rdata_valid = rsp_valid;

   always_comb begin
      entry_d = entry_q;
      if (push) begin
         entry_d[wr_ptr_q] = '{write: bus.i_write, addr: bus.i_addr,
                               wdata: bus.i_wdata, be: bus.i_be};
      end
   end

   // The pending flag drops at the edge that ends the response strobe cycle.
   always_comb begin
      wr_ptr_d       = push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d       = pop  ? ~rd_ptr_q : rd_ptr_q;
      count_d        = count_q;
      read_pending_d = read_pending_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (rsp_valid)
         read_pending_d = 1'b0;
      if (push && !bus.i_write)
         read_pending_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      entry_q <= entry_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
         count_q        <= 2'd0;
         read_pending_q <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         read_pending_q <= read_pending_d;
      end
   end

endmodule

// File: tb/tb_a25_wishbone_resp_buf.sv
// Directed bench for a25_wishbone_resp_buf; response latency expectation follows
// A25_WBRESP_RDATA_REG_EN (0 cycles after ack when undefined, 1 cycle when defined).
module tb_a25_wishbone_resp_buf;

`ifdef A25_WBRESP_RDATA_REG_EN
   localparam int RSP_LAT = 1;
`else
   localparam int RSP_LAT = 0;
`endif

   logic i_clk;
   logic i_rst;
   int   n_vec;
   int   n_err;

   a25_wishbone_resp_buf_if bus ();

   a25_wishbone_resp_buf dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.i_valid     = 1'b0;
      bus.i_write     = 1'b0;
      bus.i_wdata     = '0;
      bus.i_be        = 16'hffff;
      bus.i_addr      = '0;
      bus.i_mem_ack   = 1'b0;
      bus.i_mem_rdata = '0;
   endtask

   task automatic present(input logic wr, input logic [31:0] addr,
                          input logic [127:0] wdata, input logic [15:0] be);
      bus.i_valid = 1'b1;
      bus.i_write = wr;
      bus.i_addr  = addr;
      bus.i_wdata = wdata;
      bus.i_be    = be;
   endtask

   // Checks acceptance for a momentary request, withdrawn before the next edge.
   task automatic probe_accept(input string tag, input logic exp);
      bus.i_valid = 1'b1;
      #1;
      chk(tag, bus.o_accepted, exp);
      bus.i_valid = 1'b0;
   endtask

   // Acks a head write and checks that no read response appears.
   task automatic ack_write(input string tag);
      bus.i_mem_ack = 1'b1;
      #1;
      chk({tag, "_norsp_ack"}, bus.o_rdata_valid, 1'b0);
      tick();
      bus.i_mem_ack = 1'b0;
      #1;
      chk({tag, "_norsp_after"}, bus.o_rdata_valid, 1'b0);
   endtask

   // Acks a head read, measures strobe latency, checks data and a single pulse.
   task automatic ack_read(input string tag, input logic [127:0] d);
      int lat;
      logic [127:0] got;
      lat = -1;
      got = '0;
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = d;
      #1;
      for (int k = 0; k < 4 && lat < 0; k++) begin
         if (bus.o_rdata_valid === 1'b1) begin
            lat = k;
            got = bus.o_rdata;
         end else begin
            tick();
            bus.i_mem_ack = 1'b0;
            #1;
         end
      end
      chk({tag, "_latency"}, 128'(lat), 128'(RSP_LAT));
      chk({tag, "_rdata"}, got, d);
      tick();
      bus.i_mem_ack = 1'b0;
      #1;
      chk({tag, "_single_pulse"}, bus.o_rdata_valid, 1'b0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      idle();
      i_rst = 1'b1;
      tick();
      tick();

      // Reset state
      chk("rst_mem_req", bus.o_mem_req, 1'b0);
      chk("rst_rdata_valid", bus.o_rdata_valid, 1'b0);
      chk("rst_rdata", bus.o_rdata, 128'h0);
      probe_accept("rst_accept", 1'b1);
      i_rst = 1'b0;
      tick();

      // Single read, target acks two cycles after o_mem_req
      present(1'b0, 32'h0000_1000, '0, 16'hffff);
      #1;
      chk("rd_accept", bus.o_accepted, 1'b1);
      tick();
      present(1'b1, 32'h0000_2000, 128'h77, 16'hffff);
      #1;
      chk("rd_mem_req", bus.o_mem_req, 1'b1);
      chk("rd_mem_addr", bus.o_mem_addr, 32'h0000_1000);
      chk("rd_mem_we", bus.o_mem_we, 1'b0);
      chk("rd_refuse_0", bus.o_accepted, 1'b0);
      tick();
      chk("rd_refuse_1", bus.o_accepted, 1'b0);
      chk("rd_no_early_rsp", bus.o_rdata_valid, 1'b0);
      tick();
      chk("rd_refuse_2", bus.o_accepted, 1'b0);
      bus.i_valid = 1'b0;
      ack_read("rd", 128'hA5);
      chk("rd_drained", bus.o_mem_req, 1'b0);
      probe_accept("rd_accept_after", 1'b1);

      // Three back-to-back writes with no acks
      present(1'b1, 32'h10, 128'h1111, 16'hffff);
      #1;
      chk("w3_acc0", bus.o_accepted, 1'b1);
      tick();
      present(1'b1, 32'h20, 128'h2222, 16'h00ff);
      #1;
      chk("w3_acc1", bus.o_accepted, 1'b1);
      tick();
      present(1'b1, 32'h30, 128'h3333, 16'hff00);
      #1;
      chk("w3_refuse_a", bus.o_accepted, 1'b0);
      tick();
      chk("w3_refuse_b", bus.o_accepted, 1'b0);
      chk("w3_head0", bus.o_mem_addr, 32'h10);
      bus.i_mem_ack = 1'b1;
      #1;
      chk("w3_refuse_in_ack", bus.o_accepted, 1'b0);
      tick();
      bus.i_mem_ack = 1'b0;
      #1;
      chk("w3_acc2", bus.o_accepted, 1'b1);
      chk("w3_head1", bus.o_mem_addr, 32'h20);
      chk("w3_head1_be", bus.o_mem_be, 16'h00ff);
      tick();
      bus.i_valid = 1'b0;
      probe_accept("w3_full_again", 1'b0);
      ack_write("w3_a1");
      chk("w3_head2", bus.o_mem_addr, 32'h30);
      chk("w3_head2_wdata", bus.o_mem_wdata, 128'h3333);
      ack_write("w3_a2");
      chk("w3_drained", bus.o_mem_req, 1'b0);

      // Push and pop in the same cycle at count 1
      present(1'b1, 32'h40, 128'h4444, 16'hffff);
      tick();
      present(1'b1, 32'h50, 128'h5555, 16'h0f0f);
      bus.i_mem_ack = 1'b1;
      #1;
      chk("pp_accept", bus.o_accepted, 1'b1);
      chk("pp_head_old", bus.o_mem_addr, 32'h40);
      tick();
      bus.i_valid   = 1'b0;
      bus.i_mem_ack = 1'b0;
      #1;
      chk("pp_req", bus.o_mem_req, 1'b1);
      chk("pp_head_new", bus.o_mem_addr, 32'h50);
      chk("pp_head_be", bus.o_mem_be, 16'h0f0f);
      probe_accept("pp_count1", 1'b1);
      ack_write("pp_a");
      chk("pp_drained", bus.o_mem_req, 1'b0);

      // Write then read queued
      present(1'b1, 32'h60, 128'h6666, 16'h000f);
      tick();
      present(1'b0, 32'h70, '0, 16'hffff);
      #1;
      chk("wr_rd_accept", bus.o_accepted, 1'b1);
      tick();
      bus.i_valid = 1'b0;
      #1;
      chk("wr_rd_be0", bus.o_mem_be, 16'h000f);
      chk("wr_rd_we0", bus.o_mem_we, 1'b1);
      probe_accept("wr_rd_pending", 1'b0);
      ack_write("wr_rd_w");
      chk("wr_rd_be1", bus.o_mem_be, 16'hffff);
      chk("wr_rd_addr1", bus.o_mem_addr, 32'h70);
      chk("wr_rd_we1", bus.o_mem_we, 1'b0);
      ack_read("wr_rd_r", 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
      probe_accept("wr_rd_accept_after", 1'b1);

      // Reset while a read is pending with count 2
      present(1'b1, 32'h80, 128'h8888, 16'hffff);
      tick();
      present(1'b0, 32'h90, '0, 16'hffff);
      tick();
      bus.i_valid = 1'b0;
      #1;
      chk("rst2_req_before", bus.o_mem_req, 1'b1);
      i_rst = 1'b1;
      bus.i_mem_rdata = '0;
      #1;
      chk("rst2_req_now", bus.o_mem_req, 1'b0);
      chk("rst2_valid_now", bus.o_rdata_valid, 1'b0);
      chk("rst2_rdata_now", bus.o_rdata, 128'h0);
      tick();
      i_rst = 1'b0;
      tick();
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = 128'hDEAD;
      #1;
      chk("stray_valid_a", bus.o_rdata_valid, 1'b0);
      chk("stray_req", bus.o_mem_req, 1'b0);
      tick();
      bus.i_mem_ack = 1'b0;
      #1;
      chk("stray_valid_b", bus.o_rdata_valid, 1'b0);
      tick();
      chk("stray_valid_c", bus.o_rdata_valid, 1'b0);
      probe_accept("stray_accept", 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
